// File: rtl/rv32i_pkg.sv
// rv32i shared definitions.
// Instruction-cache geometry and refill state.
package rv32i_pkg;

    localparam int XLEN        = 32;
    localparam int IcNumLines  = 16;
    localparam int IcLineWords = 4;
    localparam int IcOffW      = $clog2(IcLineWords);
    localparam int IcIdxW      = $clog2(IcNumLines);
    localparam int IcTagW      = XLEN - IcIdxW - IcOffW - 2;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DONE
    } icache_state_e;

endpackage

// File: rtl/icache_refill_fsm.sv
// I-cache line refill sequencer.
// Owns state, word counter, pending flush and memory handshake.
module icache_refill_fsm
    import rv32i_pkg::*;
#(
    parameter int DPW       = XLEN,
    parameter int LineWords = IcLineWords,
    parameter int OffW      = $clog2(LineWords)
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start,
    input  logic [DPW-1:0]  start_base,
    input  logic            flush,
    input  logic            mem_ack,
    output icache_state_e   state,
    output logic [OffW-1:0] cnt,
    output logic [DPW-1:0]  base,
    output logic            mem_req,
    output logic [DPW-1:0]  mem_addr,
    output logic            wr_en,
    output logic            commit,
    output logic            commit_valid
);

    icache_state_e   state_q, state_d;
    logic [OffW-1:0] cnt_q, cnt_d;
    logic [DPW-1:0]  base_q, base_d;
    logic            pend_q, pend_d;

    // State, counter, base and pending-flush registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        pend_d       = pend_q;
        mem_req      = 1'b0;
        wr_en        = 1'b0;
        commit       = 1'b0;
        commit_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = start_base;
                    cnt_d   = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (flush) pend_d = 1'b1;
                if (mem_ack) begin
                    wr_en = 1'b1;
                    if (cnt_q == OffW'(LineWords - 1)) begin
                        commit       = 1'b1;
                        commit_valid = ~(pend_q | flush);
                        cnt_d        = '0;
                        state_d      = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state    = state_q;
    assign cnt      = cnt_q;
    assign base     = base_q;
    assign mem_addr = mem_req ? base_q + (DPW'(cnt_q) << 2) : '0;

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache for the rv32i fetch stage.
// Zero-latency hits; misses stall while a line is refilled.
module i_cache_dm
    import rv32i_pkg::*;
#(
    parameter int DPW       = XLEN,
    parameter int NumLines  = IcNumLines,
    parameter int LineWords = IcLineWords
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic [DPW-1:0] PCF,
    input  logic           fetch_en,
    input  logic           flush,
    output logic [DPW-1:0] instr,
    output logic           hit,
    output logic           stall_f,
    output logic           mem_req,
    output logic [DPW-1:0] mem_addr,
    input  logic           mem_ack,
    input  logic [DPW-1:0] mem_rdata
);

    localparam int OffW = $clog2(LineWords);
    localparam int IdxW = $clog2(NumLines);
    localparam int TagW = DPW - IdxW - OffW - 2;

    logic [DPW-1:0]  data_q [NumLines*LineWords];
    logic [TagW-1:0] tag_q  [NumLines];
    logic [NumLines-1:0] valid_q;

    icache_state_e   state;
    logic [OffW-1:0] cnt;
    logic [DPW-1:0]  base;
    logic            wr_en, commit, commit_valid;

    logic [OffW-1:0] off;
    logic [IdxW-1:0] idx, ridx;
    logic [TagW-1:0] tag;
    logic            idle, lookup_hit, miss;
    logic [DPW-1:0]  start_base;

    assign off  = PCF[OffW+1:2];
    assign idx  = PCF[OffW+2 +: IdxW];
    assign tag  = PCF[DPW-1 -: TagW];
    assign ridx = base[OffW+2 +: IdxW];
    assign idle = (state == IDLE);

    assign lookup_hit = idle & fetch_en & ~flush
                      & valid_q[idx] & (tag_q[idx] == tag);
    assign miss       = idle & fetch_en & ~lookup_hit;
    assign start_base = {PCF[DPW-1:OffW+2], {(OffW+2){1'b0}}};

    assign hit     = lookup_hit;
    assign instr   = lookup_hit ? data_q[{idx, off}] : '0;
    assign stall_f = arst_n & (miss | ~idle);

    logic unused_bits;
    assign unused_bits = ^{PCF[1:0], base[OffW+1:0]};

    icache_refill_fsm #(
        .DPW       (DPW),
        .LineWords (LineWords),
        .OffW      (OffW)
    ) u_fsm (
        .clk          (clk),
        .arst_n       (arst_n),
        .start        (miss),
        .start_base   (start_base),
        .flush        (flush),
        .mem_ack      (mem_ack),
        .state        (state),
        .cnt          (cnt),
        .base         (base),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .wr_en        (wr_en),
        .commit       (commit),
        .commit_valid (commit_valid)
    );

    // Data and tag storage; contents are gated by valid, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) data_q[{ridx, cnt}] <= mem_rdata;
        if (commit) tag_q[ridx] <= base[DPW-1 -: TagW];
    end

    // Valid bits: whole-cache clear on flush, set on a clean commit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= '0;
        end else if (flush && state != REFILL) begin
            valid_q <= '0;
        end else if (commit) begin
            if (commit_valid) valid_q[ridx] <= 1'b1;
            else              valid_q       <= '0;
        end
    end

endmodule

// File: tb/tb_i_cache_dm.sv
// Bench for i_cache_dm: directed plan plus random fetches
// checked against a line-level cache model.
module tb_i_cache_dm;

    localparam int LW = 4;
    localparam int NL = 16;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] PCF;
    logic        fetch_en, flush;
    logic [31:0] instr, mem_addr, mem_rdata;
    logic        hit, stall_f, mem_req, mem_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int wait_states = 0;
    int wcnt;

    bit          mvalid [NL];
    logic [23:0] mtag   [NL];

    i_cache_dm dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .PCF       (PCF),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .instr     (instr),
        .hit       (hit),
        .stall_f   (stall_f),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] t [4];
        t[0] = 32'h00022203;
        t[1] = 32'h0042A283;
        t[2] = 32'h00C3A383;
        t[3] = 32'h01042403;
        if (a < 32'h10) return t[a[3:2]];
        return {a[15:0], ~a[15:0]} ^ 32'h0BAD_F00D;
    endfunction

    // Backing memory with a fixed number of wait cycles per word.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n)                wcnt <= 0;
        else if (!mem_req || mem_ack) wcnt <= 0;
        else                        wcnt <= wcnt + 1;
    end
    assign mem_ack   = mem_req && (wcnt >= wait_states);
    assign mem_rdata = mem_word(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // PCF must hold while the cache stalls.
    logic        stall_q = 1'b0;
    logic [31:0] pcf_q   = '0;
    always @(posedge clk) begin
        if (stall_q) chk("pcf_hold", PCF, pcf_q);
        stall_q <= stall_f;
        pcf_q   <= PCF;
    end

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    endfunction

    // fmode: 0 plain, 1 flush on first cycle, 2 flush during word 2.
    task automatic fetch(input logic [31:0] pc, input int ws,
                         input int fmode);
        int idx, stalls, acks, cyc;
        logic [23:0] tg;
        logic [31:0] lbase;
        bit exp_hit, saw_hit;
        idx   = int'(pc[7:4]);
        tg    = pc[31:8];
        lbase = {pc[31:4], 4'h0};
        wait_states = ws;
        @(negedge clk);
        PCF = pc; fetch_en = 1'b1; flush = (fmode == 1);
        #1;
        exp_hit = (fmode != 1) && mvalid[idx] && (mtag[idx] == tg);
        if (exp_hit) begin
            chk("hit", {31'b0, hit}, 32'd1);
            chk("hit_stall", {31'b0, stall_f}, 32'd0);
            chk("hit_req", {31'b0, mem_req}, 32'd0);
            chk("hit_instr", instr, mem_word(pc));
        end else begin
            chk("miss_hit", {31'b0, hit}, 32'd0);
            chk("miss_stall", {31'b0, stall_f}, 32'd1);
            if (fmode == 1) model_clear();
            stalls = 1; acks = 0; cyc = 0; saw_hit = 1'b0;
            while (cyc < 300) begin
                @(negedge clk);
                flush = (fmode == 2 && acks == 1);
                #1;
                cyc++;
                if (hit) begin
                    saw_hit = 1'b1;
                    break;
                end
                if (stall_f) stalls++;
                if (mem_req) begin
                    chk("addr", mem_addr, lbase + 32'(4 * acks));
                    if (mem_ack) acks++;
                end
                if (fmode == 2 && acks == LW && stall_f && !mem_req)
                    break;
            end
            chk("timeout", {31'b0, (cyc < 300)}, 32'd1);
            chk("stalls", 32'(stalls), 32'(LW * (ws + 1) + 2));
            if (fmode == 2) begin
                model_clear();
                @(negedge clk);
                flush = 1'b0; fetch_en = 1'b0;
            end else begin
                chk("fill_hit", {31'b0, saw_hit}, 32'd1);
                chk("fill_instr", instr, mem_word(pc));
                chk("fill_req", {31'b0, mem_req}, 32'd0);
                mvalid[idx] = 1'b1;
                mtag[idx]   = tg;
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        int acks, cyc;
        arst_n = 1'b0; PCF = '0; fetch_en = 1'b0; flush = 1'b0;
        model_clear();
        #12;
        chk("rst_hit", {31'b0, hit}, 32'd0);
        chk("rst_stall", {31'b0, stall_f}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        @(negedge clk); arst_n = 1'b1;

        // Cold miss, warm hits, conflict eviction.
        fetch(32'h0, 0, 0);
        fetch(32'h4, 0, 0);
        fetch(32'h8, 0, 0);
        fetch(32'hC, 0, 0);
        fetch(32'h100, 0, 0);
        fetch(32'h0, 0, 0);

        // Disabled fetch does nothing.
        @(negedge clk); fetch_en = 1'b0; PCF = 32'h0; #1;
        chk("noen_hit", {31'b0, hit}, 32'd0);
        chk("noen_stall", {31'b0, stall_f}, 32'd0);

        // Wait states, then flushes.
        fetch(32'h20, 3, 0);
        fetch(32'h24, 0, 0);
        fetch(32'h0, 0, 1);
        fetch(32'h0, 1, 2);
        fetch(32'h20, 0, 0);
        fetch(32'h0, 0, 0);

        // Reset during the second refill word.
        fetch(32'h34, 0, 0);
        wait_states = 3;
        @(negedge clk); PCF = 32'h40; fetch_en = 1'b1;
        acks = 0; cyc = 0;
        while (acks < 1 && cyc < 100) begin
            @(negedge clk); #1; cyc++;
            if (mem_ack) acks++;
        end
        chk("rst_wait", {31'b0, (cyc < 100)}, 32'd1);
        @(negedge clk); #1;
        arst_n = 1'b0; #1;
        chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall_f}, 32'd0);
        model_clear();
        @(negedge clk); arst_n = 1'b1; fetch_en = 1'b0;
        fetch(32'h40, 0, 0);
        fetch(32'h34, 0, 0);

        // Random traffic.
        for (int k = 0; k < 80; k++) begin
            logic [31:0] pc;
            int r;
            pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4)
               | ($urandom_range(0, 3) << 2);
            r = $urandom_range(0, 19);
            fetch(pc, $urandom_range(0, 2), (r == 0) ? 1 : (r == 1) ? 2 : 0);
        end

        @(negedge clk); fetch_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
